// File: rtl/mcp3008_scan_scheduler.sv
// MCP3008 scan scheduler: dclk divider, scan FSM, busy sync, result handshake.
// Define MCP3008_SCAN_AVG_EN to deliver the average of four captures.
module mcp3008_scan_scheduler #(
   parameter int DCLK_DIV     = 4,
   parameter int PERIOD_W     = 16,
   parameter int TIMEOUT_DCLK = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                trigger,
   input  logic [PERIOD_W-1:0] period,
   output logic                dclk,
   output logic                sample,
   input  logic                adc_busy,
   input  logic [31:0]         adc_data,
   output logic [9:0]          result_a,
   output logic [9:0]          result_b,
   output logic                result_valid,
   input  logic                result_ack,
   output logic                overrun,
   output logic                frame_err,
   output logic                timeout_err,
   input  logic                err_clr
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] REQ     = 3'd1;
   localparam logic [2:0] CONV    = 3'd2;
   localparam logic [2:0] CAPTURE = 3'd3;
   localparam logic [2:0] WAIT    = 3'd4;

   localparam int TW = $clog2(2 * TIMEOUT_DCLK + 1);
   localparam logic [7:0]    DIV_LAST = 8'(DCLK_DIV - 1);
   localparam logic [TW-1:0] T_REQ    = TW'(TIMEOUT_DCLK - 1);
   localparam logic [TW-1:0] T_CONV   = TW'(2 * TIMEOUT_DCLK - 1);

   logic [2:0]          state;
   logic [7:0]          div_cnt;
   logic                dclk_rise;
   logic                busy_m;
   logic                busy_s;
   logic [TW-1:0]       t_cnt;
   logic [PERIOD_W-1:0] p_cnt;
   logic                start;
   logic                capture;
   logic                timeout_set;
   logic                frame_bad;
   logic                out_en;
   logic                burst;
   logic [9:0]          cap_a;
   logic [9:0]          cap_b;
   logic [9:0]          out_a;
   logic [9:0]          out_b;
   logic                unused;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         dclk    <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         dclk    <= ~dclk;
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

   assign dclk_rise = (div_cnt == DIV_LAST) && !dclk;

   // The interface is not reset with us, so assume busy until proven idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_m <= 1'b1;
         busy_s <= 1'b1;
      end else begin
         busy_m <= adc_busy;
         busy_s <= busy_m;
      end
   end

   assign start   = (state == IDLE) && !busy_s && (enable || trigger || burst);
   assign capture = (state == CAPTURE);
   assign sample  = (state == REQ);

   assign timeout_set = dclk_rise && (
      (state == REQ  && !busy_s && t_cnt == T_REQ) ||
      (state == CONV &&  busy_s && t_cnt == T_CONV));

   // Period counts from scan start; exiting WAIT at 2 lands the next REQ on time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         t_cnt <= '0;
         p_cnt <= '0;
      end else begin
         if (state != IDLE && p_cnt != '0)
            p_cnt <= p_cnt - PERIOD_W'(1);
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= REQ;
                  p_cnt <= period;
                  t_cnt <= '0;
               end
            end
            REQ: begin
               if (busy_s) begin
                  state <= CONV;
                  t_cnt <= '0;
               end else if (timeout_set) begin
                  state <= IDLE;
               end else if (dclk_rise) begin
                  t_cnt <= t_cnt + TW'(1);
               end
            end
            CONV: begin
               if (!busy_s) begin
                  state <= CAPTURE;
               end else if (timeout_set) begin
                  state <= IDLE;
               end else if (dclk_rise) begin
                  t_cnt <= t_cnt + TW'(1);
               end
            end
            CAPTURE: state <= enable ? WAIT : IDLE;
            WAIT: begin
               if (p_cnt <= PERIOD_W'(2))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cap_a     = adc_data[25:16];
   assign cap_b     = adc_data[9:0];
   assign frame_bad = capture && !(adc_data[26] && adc_data[10]);

`ifdef MCP3008_SCAN_AVG_EN
   logic [1:0]  avg_cnt;
   logic [11:0] acc_a;
   logic [11:0] acc_b;
   logic [11:0] sum_a;
   logic [11:0] sum_b;

   assign sum_a  = acc_a + {2'b00, cap_a};
   assign sum_b  = acc_b + {2'b00, cap_b};
   assign out_en = capture && (avg_cnt == 2'd3);
   assign out_a  = sum_a[11:2];
   assign out_b  = sum_b[11:2];
   assign unused = ^{adc_data[31:27], adc_data[15:11],
                     sum_a[1:0], sum_b[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         avg_cnt <= '0;
         acc_a   <= '0;
         acc_b   <= '0;
      end else if (capture) begin
         avg_cnt <= avg_cnt + 2'd1;
         acc_a   <= out_en ? 12'd0 : sum_a;
         acc_b   <= out_en ? 12'd0 : sum_b;
      end
   end

   // A single trigger keeps scanning until the fourth capture completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         burst <= 1'b0;
      else if (start && !enable && trigger)
         burst <= 1'b1;
      else if (out_en || timeout_set)
         burst <= 1'b0;
   end
`else
   assign out_en = capture;
   assign out_a  = cap_a;
   assign out_b  = cap_b;
   assign burst  = 1'b0;
   assign unused = ^{adc_data[31:27], adc_data[15:11]};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_a     <= '0;
         result_b     <= '0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
         frame_err    <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         if (out_en) begin
            result_a     <= out_a;
            result_b     <= out_b;
            result_valid <= 1'b1;
         end else if (result_ack) begin
            result_valid <= 1'b0;
         end
         overrun     <= (out_en && result_valid && !result_ack) ||
                        (overrun && !err_clr);
         frame_err   <= frame_bad || (frame_err && !err_clr);
         timeout_err <= timeout_set || (timeout_err && !err_clr);
      end
   end

endmodule

// File: tb/tb_mcp3008_scan_scheduler.sv
// Bench for mcp3008_scan_scheduler: dclk-domain ADC model plus scoreboard.
// Averaging checks run when MCP3008_SCAN_AVG_EN is defined.
module tb_mcp3008_scan_scheduler;

   localparam int DIV  = 4;
   localparam int TMO  = 64;
   localparam int CONV = 36;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        trigger = 1'b0;
   logic        result_ack = 1'b0;
   logic        err_clr = 1'b0;
   logic [15:0] period = 16'd400;
   logic        adc_busy = 1'b0;
   logic [31:0] adc_data = '0;
   logic        dclk;
   logic        sample;
   logic [9:0]  result_a;
   logic [9:0]  result_b;
   logic        result_valid;
   logic        overrun;
   logic        frame_err;
   logic        timeout_err;

   int cmp = 0;
   int bad = 0;
   int cyc = 0;
   int rises = 0;
   int rise_cyc[$];
   logic sample_d = 1'b0;
   logic [31:0] word_q[$];
   logic [31:0] exp_q[$];
   bit bfm_mute = 1'b0;

   mcp3008_scan_scheduler #(
      .DCLK_DIV(DIV), .PERIOD_W(16), .TIMEOUT_DCLK(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger),
      .period(period), .dclk(dclk), .sample(sample),
      .adc_busy(adc_busy), .adc_data(adc_data),
      .result_a(result_a), .result_b(result_b),
      .result_valid(result_valid), .result_ack(result_ack),
      .overrun(overrun), .frame_err(frame_err),
      .timeout_err(timeout_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (sample && !sample_d) begin
         rises <= rises + 1;
         rise_cyc.push_back(cyc);
      end
      sample_d <= sample;
   end

   // ADC model: answers a request after 2 dclk, stays busy CONV dclk.
   initial begin : bfm
      logic [31:0] w;
      forever begin
         @(posedge dclk);
         #1;
         if (sample && !adc_busy && !bfm_mute) begin
            repeat (2) @(posedge dclk);
            #1 adc_busy = 1'b1;
            repeat (CONV) @(posedge dclk);
            #1;
            if (word_q.size() > 0) w = word_q.pop_front();
            else w = $urandom | 32'h0400_0400;
            adc_data = w;
            exp_q.push_back(w);
            adc_busy = 1'b0;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic wait_valid(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (result_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_trigger();
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
   endtask

   task automatic pulse_ack();
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic quiesce();
      enable = 1'b0;
      trigger = 1'b0;
      bfm_mute = 1'b0;
      result_ack = 1'b1;
      repeat (700) @(negedge clk);
      result_ack = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      exp_q.delete();
      word_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      cmp++;
      if (dclk !== 1'b0) begin
         bad++;
         $display("FAIL reset_dclk: got %b want 0", dclk);
      end
      cmp++;
      if (sample !== 1'b0) begin
         bad++;
         $display("FAIL reset_sample: got %b want 0", sample);
      end
      cmp++;
      if (result_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid: got %b want 0", result_valid);
      end
      cmp++;
      if ({result_a, result_b} !== 20'd0) begin
         bad++;
         $display("FAIL reset_results: got %h/%h want 0/0",
                  result_a, result_b);
      end
      cmp++;
      if ({overrun, frame_err, timeout_err} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags: got %b want 000",
                  {overrun, frame_err, timeout_err});
      end
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      cmp++;
      if (rises != 0) begin
         bad++;
         $display("FAIL idle_no_sample: got %0d rises want 0", rises);
      end
   endtask

   task automatic test_dclk();
      int t0;
      int n;
      logic prev;
      n = 0;
      t0 = 0;
      prev = dclk;
      for (int i = 0; i < 100 && n < 2; i++) begin
         @(negedge clk);
         if (dclk && !prev) begin
            n++;
            if (n == 1) t0 = i;
            else begin
               cmp++;
               if (i - t0 != 2 * DIV) begin
                  bad++;
                  $display("FAIL dclk_period: got %0d want %0d",
                           i - t0, 2 * DIV);
               end
            end
         end
         prev = dclk;
      end
      cmp++;
      if (n < 2) begin
         bad++;
         $display("FAIL dclk_running: got %0d edges want 2", n);
      end
   endtask

   task automatic test_continuous();
      bit ok;
      int r0;
      logic [31:0] w;
      word_q.push_back(32'h07FF_07FF);
      period = 16'd400;
      r0 = rise_cyc.size();
      enable = 1'b1;
      for (int n = 0; n < 4; n++) begin
         wait_valid(1200, ok);
         cmp++;
         if (!ok || exp_q.size() == 0) begin
            bad++;
            $display("FAIL cont_valid: got ok=%0d q=%0d want 1/1",
                     ok, exp_q.size());
            break;
         end
         w = exp_q.pop_front();
         cmp++;
         if ({result_a, result_b} !== {w[25:16], w[9:0]}) begin
            bad++;
            $display("FAIL cont_data: got %h/%h want %h/%h",
                     result_a, result_b, w[25:16], w[9:0]);
         end
         cmp++;
         if (frame_err !== 1'b0) begin
            bad++;
            $display("FAIL cont_frame: got %b want 0", frame_err);
         end
         pulse_ack();
      end
      enable = 1'b0;
      repeat (20) @(negedge clk);
      cmp++;
      if (rise_cyc.size() < r0 + 4) begin
         bad++;
         $display("FAIL cont_rises: got %0d want >=4",
                  rise_cyc.size() - r0);
      end else begin
         for (int i = 1; i < 4; i++) begin
            cmp++;
            if (rise_cyc[r0+i] - rise_cyc[r0+i-1] != int'(period)) begin
               bad++;
               $display("FAIL cont_period: got %0d want %0d",
                        rise_cyc[r0+i] - rise_cyc[r0+i-1], period);
            end
         end
      end
   endtask

   task automatic test_single();
      bit ok;
      int r0;
      logic [31:0] w;
      enable = 1'b0;
      r0 = rises;
      word_q.push_back(32'h0601_0402);
      for (int n = 0; n < 3; n++) begin
         pulse_trigger();
         if (n == 0) begin
            for (int i = 0; i < 600 && !adc_busy; i++)
               @(negedge clk);
            repeat (20) @(negedge clk);
            pulse_trigger();
         end
         wait_valid(1200, ok);
         cmp++;
         if (!ok || exp_q.size() == 0) begin
            bad++;
            $display("FAIL single_valid: got ok=%0d want 1", ok);
            break;
         end
         w = exp_q.pop_front();
         cmp++;
         if ({result_a, result_b} !== {w[25:16], w[9:0]}) begin
            bad++;
            $display("FAIL single_data: got %h/%h want %h/%h",
                     result_a, result_b, w[25:16], w[9:0]);
         end
         pulse_ack();
         repeat (600) @(negedge clk);
         cmp++;
         if (rises - r0 != n + 1) begin
            bad++;
            $display("FAIL single_pulses: got %0d want %0d",
                     rises - r0, n + 1);
         end
      end
   endtask

   task automatic test_overrun();
      bit ok;
      logic prev;
      logic [31:0] w;
      enable = 1'b1;
      period = 16'd400;
      wait_valid(1200, ok);
      repeat (4) @(negedge clk);
      cmp++;
      if (!ok || overrun !== 1'b0) begin
         bad++;
         $display("FAIL ovr_first: got ok=%0d ovr=%b want 1/0",
                  ok, overrun);
      end
      for (int i = 0; i < 1200 && exp_q.size() < 2; i++)
         @(negedge clk);
      repeat (6) @(negedge clk);
      w = (exp_q.size() >= 2) ? exp_q[1] : 32'h0;
      cmp++;
      if (overrun !== 1'b1 || result_a !== w[25:16]) begin
         bad++;
         $display("FAIL ovr_second: got ovr=%b a=%h want 1/%h",
                  overrun, result_a, w[25:16]);
      end
      pulse_clr();
      cmp++;
      if (overrun !== 1'b0 || result_valid !== 1'b1) begin
         bad++;
         $display("FAIL ovr_clear: got ovr=%b v=%b want 0/1",
                  overrun, result_valid);
      end
      prev = adc_busy;
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         if (prev && !adc_busy) break;
         prev = adc_busy;
      end
      w = adc_data;
      repeat (3) @(negedge clk);
      pulse_ack();
      cmp++;
      if (result_valid !== 1'b1 || overrun !== 1'b0 ||
          result_a !== w[25:16]) begin
         bad++;
         $display("FAIL ovr_coincide: got v=%b ovr=%b a=%h want 1/0/%h",
                  result_valid, overrun, result_a, w[25:16]);
      end
   endtask

   task automatic test_frame();
      bit ok;
      logic [31:0] w;
      logic want;
      enable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         w = $urandom;
         w[26] = (k == 1 || k == 2);
         w[10] = (k == 0 || k == 2);
         want = !(w[26] && w[10]);
         word_q.push_back(w);
         pulse_trigger();
         wait_valid(1200, ok);
         cmp++;
         if (!ok || frame_err !== want) begin
            bad++;
            $display("FAIL frame_flag: got ok=%0d fe=%b want 1/%b",
                     ok, frame_err, want);
         end
         cmp++;
         if ({result_a, result_b} !== {w[25:16], w[9:0]}) begin
            bad++;
            $display("FAIL frame_data: got %h/%h want %h/%h",
                     result_a, result_b, w[25:16], w[9:0]);
         end
         pulse_ack();
         pulse_clr();
         cmp++;
         if (frame_err !== 1'b0) begin
            bad++;
            $display("FAIL frame_clear: got %b want 0", frame_err);
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int n;
      logic [31:0] w;
      enable = 1'b0;
      bfm_mute = 1'b1;
      pulse_trigger();
      for (int i = 0; i < 20 && !sample; i++) @(negedge clk);
      n = 0;
      while (!timeout_err && n < 2 * DIV * TMO + 100) begin
         @(negedge clk);
         n++;
      end
      cmp++;
      if (n < 2 * DIV * (TMO - 1) || n > 2 * DIV * TMO + 1) begin
         bad++;
         $display("FAIL tmo_time: got %0d clk want %0d..%0d", n,
                  2 * DIV * (TMO - 1), 2 * DIV * TMO + 1);
      end
      cmp++;
      if (sample !== 1'b0 || timeout_err !== 1'b1) begin
         bad++;
         $display("FAIL tmo_state: got s=%b te=%b want 0/1",
                  sample, timeout_err);
      end
      bfm_mute = 1'b0;
      repeat (10) @(negedge clk);
      pulse_trigger();
      wait_valid(1200, ok);
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
      cmp++;
      if (!ok || result_a !== w[25:16] || timeout_err !== 1'b1) begin
         bad++;
         $display("FAIL tmo_retry: got ok=%0d a=%h te=%b want 1/%h/1",
                  ok, result_a, timeout_err, w[25:16]);
      end
      pulse_ack();
      pulse_clr();
      cmp++;
      if (timeout_err !== 1'b0) begin
         bad++;
         $display("FAIL tmo_clear: got %b want 0", timeout_err);
      end
   endtask

   task automatic test_reset_mid();
      int viol;
      int n;
      enable = 1'b1;
      period = 16'd400;
      for (int i = 0; i < 600 && !adc_busy; i++) @(negedge clk);
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      #1;
      cmp++;
      if ({sample, result_valid, dclk} !== 3'b000) begin
         bad++;
         $display("FAIL rstmid_outputs: got %b want 000",
                  {sample, result_valid, dclk});
      end
      @(negedge clk);
      rst_n = 1'b1;
      viol = 0;
      for (int i = 0; i < 600 && adc_busy; i++) begin
         @(negedge clk);
         if (sample) viol++;
      end
      cmp++;
      if (viol != 0 || adc_busy) begin
         bad++;
         $display("FAIL rstmid_hold: got %0d early requests want 0",
                  viol);
      end
      n = 0;
      while (!sample && n < 30) begin
         @(negedge clk);
         n++;
      end
      cmp++;
      if (!sample || n < 2) begin
         bad++;
         $display("FAIL rstmid_resume: got s=%b after %0d want 1 >=2",
                  sample, n);
      end
   endtask

`ifdef MCP3008_SCAN_AVG_EN
   task automatic test_avg();
      bit ok;
      int r0;
      int sum_b;
      logic [31:0] w;
      enable = 1'b0;
      sum_b = 0;
      for (int k = 0; k < 4; k++) begin
         w = $urandom | 32'h0400_0400;
         w[25:16] = 10'(100 + k);
         sum_b += int'(w[9:0]);
         word_q.push_back(w);
      end
      r0 = rises;
      pulse_trigger();
      wait_valid(3000, ok);
      cmp++;
      if (!ok || exp_q.size() != 4) begin
         bad++;
         $display("FAIL avg_valid: got ok=%0d caps=%0d want 1/4",
                  ok, exp_q.size());
      end
      cmp++;
      if (result_a !== 10'd101 || result_b !== 10'(sum_b / 4)) begin
         bad++;
         $display("FAIL avg_data: got %0d/%0d want 101/%0d",
                  result_a, result_b, sum_b / 4);
      end
      pulse_ack();
      repeat (800) @(negedge clk);
      cmp++;
      if (rises - r0 != 4 || result_valid !== 1'b0) begin
         bad++;
         $display("FAIL avg_count: got %0d scans v=%b want 4/0",
                  rises - r0, result_valid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_dclk();
`ifdef MCP3008_SCAN_AVG_EN
      test_avg();
`else
      test_continuous();
      quiesce();
      test_single();
      quiesce();
      test_overrun();
      quiesce();
      test_frame();
      quiesce();
      test_timeout();
      quiesce();
      test_reset_mid();
      quiesce();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule
